// File: rtl/isa_pkg.sv
// Shared ISA constants for the multi-cycle core: instruction field positions
// and the fetch sequencer state encoding.
package isa_pkg;

  localparam int STOP_BIT   = 0;
  localparam int TYPE_LSB   = 1;
  localparam int TYPE_MSB   = 2;
  localparam int OPCODE_LSB = 27;
  localparam int OPCODE_MSB = 31;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t FETCH_IDLE = 3'd0;
  localparam fetch_state_t FETCH_ADDR = 3'd1;
  localparam fetch_state_t FETCH_WAIT = 3'd2;
  localparam fetch_state_t FETCH_HOLD = 3'd3;
  localparam fetch_state_t FETCH_HALT = 3'd4;

  typedef struct packed {
    logic [OPCODE_MSB-OPCODE_LSB:0] opcode;
    logic [TYPE_MSB-TYPE_LSB:0]     itype;
    logic                           stop;
  } instr_fields_t;

  function automatic logic is_stop(input logic [31:0] instr);
    return instr[STOP_BIT];
  endfunction

  function automatic instr_fields_t decode_fields(input logic [31:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    f.itype  = instr[TYPE_MSB:TYPE_LSB];
    f.stop   = instr[STOP_BIT];
    return f;
  endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Loadable 4-bit down-counter that times memory read latency; done flags zero.
// Shared between the instruction fetch and data-memory controllers.
module fetch_wait_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 4'd0);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, waits out memory latency, holds the
// fetched word in the IR until the control unit takes it, and handles redirects.
module instr_fetch_ctrl
  import isa_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                MEM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  // WAIT runs for exactly MEM_LATENCY cycles, so the counter starts one short.
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

  fetch_state_t      state_q,       state_d;
  logic [ADDR_W-1:0] pc_q,          pc_d;
  logic [31:0]       ir_q,          ir_d;
  logic              ir_valid_q,    ir_valid_d;
  logic              halted_q,      halted_d;
  logic [15:0]       fetch_count_q, fetch_count_d;

  logic cnt_load;
  logic cnt_en;
  logic cnt_done;

  fetch_wait_counter u_wait_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;

    case (state_q)
      FETCH_IDLE: begin
        if (start) begin
          state_d = FETCH_ADDR;
        end
      end
      FETCH_ADDR: begin
        cnt_load = 1'b1;
        state_d  = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (cnt_done) begin
          ir_d       = imem_data;
          ir_valid_d = 1'b1;
          state_d    = FETCH_HOLD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (ir_ready) begin
          ir_valid_d = 1'b0;
          if (fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
          end
          if (is_stop(ir_q)) begin
            halted_d = 1'b1;
            state_d  = FETCH_HALT;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = FETCH_ADDR;
          end
        end
      end
      FETCH_HALT: begin
        state_d = FETCH_HALT;
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase

    // Redirect beats everything outside IDLE, including a same-cycle accept:
    // the held word is dropped uncounted and a completing read is discarded.
    if (redirect && (state_q != FETCH_IDLE)) begin
      pc_d          = redirect_pc;
      ir_d          = ir_q;
      ir_valid_d    = 1'b0;
      halted_d      = 1'b0;
      fetch_count_d = fetch_count_q;
      cnt_en        = 1'b0;
      state_d       = FETCH_ADDR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= 32'd0;
      ir_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;
  assign busy        = (state_q == FETCH_ADDR) || (state_q == FETCH_WAIT) ||
                       (state_q == FETCH_HOLD);

endmodule
